// File: rtl/reg_wb_queue.sv
// In-order writeback queue feeding the reg_file write port, with two forwarding lookups.
// Optional feature: define WB_BYPASS_EN to let a result hit the write port directly when the queue is empty.
module reg_wb_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wb_stall,
  output logic                     write_en,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        look_addr_1,
  output logic                     look_hit_1,
  output logic [DATA_W-1:0]        look_data_1,
  input  logic [ADDR_W-1:0]        look_addr_2,
  output logic                     look_hit_2,
  output logic [DATA_W-1:0]        look_data_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic drop;
  logic bypass;
  logic enq;
  logic drain;

  assign in_ready = (count_q < CW'(DEPTH));
  assign drop     = (ZERO_REG != 0) && (in_addr == '0);
  assign drain    = (count_q != '0) && !wb_stall;
`ifdef WB_BYPASS_EN
  // Gated by rst so a result presented during reset never reaches the port.
  assign bypass   = (count_q == '0) && !wb_stall && in_valid && !rst && !drop;
`else
  assign bypass   = 1'b0;
`endif
  assign enq      = in_valid && in_ready && !drop && !bypass;
  assign count    = count_q;

  always_comb begin
    write_en   = drain;
    write_addr = '0;
    write_data = '0;
    if (count_q != '0) begin
      write_addr = addr_q[head_q];
      write_data = data_q[head_q];
    end
    if (bypass) begin
      write_en   = 1'b1;
      write_addr = in_addr;
      write_data = in_data;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    if (drain) begin
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  logic [ADDR_W-1:0] look_addr [2];
  assign look_addr[0] = look_addr_1;
  assign look_addr[1] = look_addr_2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_look
    logic              hit;
    logic [DATA_W-1:0] data;
    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[head_q + PW'(i)] && (addr_q[head_q + PW'(i)] == look_addr[gi])) begin
          hit  = 1'b1;
          data = data_q[head_q + PW'(i)];
        end
      end
    end
  end

  assign look_hit_1  = g_look[0].hit;
  assign look_data_1 = g_look[0].data;
  assign look_hit_2  = g_look[1].hit;
  assign look_data_2 = g_look[1].data;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: two instances (ZERO_REG=0 and 1) share stimulus and are checked against queue models.
module tb_reg_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } ent_t;
  typedef ent_t ent_q_t[$];

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        h1;
    logic [15:0] d1;
    logic        h2;
    logic [15:0] d2;
    logic [2:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_addr;
  logic [15:0] in_data;
  logic        wb_stall;
  logic [2:0]  look1;
  logic [2:0]  look2;

  logic        rdy [2];
  logic        we  [2];
  logic [2:0]  wa  [2];
  logic [15:0] wd  [2];
  logic        h1  [2];
  logic [15:0] d1  [2];
  logic        h2  [2];
  logic [15:0] d2  [2];
  logic [2:0]  cnt [2];

  int  checks;
  int  errors;
  bit  started;
  ent_q_t q0;
  ent_q_t q1;

  reg_wb_queue #(.DEPTH(DEPTH), .ADDR_W(3), .DATA_W(16), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
    .write_en(we[0]), .write_addr(wa[0]), .write_data(wd[0]),
    .look_addr_1(look1), .look_hit_1(h1[0]), .look_data_1(d1[0]),
    .look_addr_2(look2), .look_hit_2(h2[0]), .look_data_2(d2[0]),
    .count(cnt[0])
  );

  reg_wb_queue #(.DEPTH(DEPTH), .ADDR_W(3), .DATA_W(16), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
    .write_en(we[1]), .write_addr(wa[1]), .write_data(wd[1]),
    .look_addr_1(look1), .look_hit_1(h1[1]), .look_data_1(d1[1]),
    .look_addr_2(look2), .look_hit_2(h2[1]), .look_data_2(d2[1]),
    .count(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_outs(input ent_q_t q, input bit zr);
    exp_t e;
    int   sz;
    sz    = q.size();
    e     = '0;
    e.cnt = 3'(sz);
    e.rdy = (sz < DEPTH);
    e.we  = (sz != 0) && !wb_stall;
    if (sz != 0) begin
      e.wa = q[0].a;
      e.wd = q[0].d;
    end
`ifdef WB_BYPASS_EN
    if (sz == 0 && !wb_stall && in_valid && !rst && !(zr && in_addr == 3'd0)) begin
      e.we = 1'b1;
      e.wa = in_addr;
      e.wd = in_data;
    end
`else
    if (zr) e.cnt = e.cnt;
`endif
    foreach (q[i]) begin
      if (q[i].a == look1) begin e.h1 = 1'b1; e.d1 = q[i].d; end
      if (q[i].a == look2) begin e.h2 = 1'b1; e.d2 = q[i].d; end
    end
    return e;
  endfunction

  function automatic ent_q_t nxt(input ent_q_t q, input bit zr);
    ent_q_t r;
    ent_t   n;
    int     sz;
    bit     drn, drp, byp, en;
    r  = q;
    sz = q.size();
    if (rst) begin
      r.delete();
      return r;
    end
    drn = (sz != 0) && !wb_stall;
    drp = zr && (in_addr == 3'd0);
    byp = 1'b0;
`ifdef WB_BYPASS_EN
    byp = (sz == 0) && !wb_stall && in_valid && !drp;
`endif
    en = in_valid && (sz < DEPTH) && !drp && !byp;
    if (drn) void'(r.pop_front());
    if (en) begin
      n.a = in_addr;
      n.d = in_data;
      r.push_back(n);
    end
    return r;
  endfunction

  task automatic cmp_inst(input int k, input exp_t e);
    string p;
    p = $sformatf("dut%0d", k);
    chk({p, ".in_ready"},    32'(rdy[k]), 32'(e.rdy));
    chk({p, ".write_en"},    32'(we[k]),  32'(e.we));
    chk({p, ".write_addr"},  32'(wa[k]),  32'(e.wa));
    chk({p, ".write_data"},  32'(wd[k]),  32'(e.wd));
    chk({p, ".look_hit_1"},  32'(h1[k]),  32'(e.h1));
    chk({p, ".look_data_1"}, 32'(d1[k]),  32'(e.d1));
    chk({p, ".look_hit_2"},  32'(h2[k]),  32'(e.h2));
    chk({p, ".look_data_2"}, 32'(d2[k]),  32'(e.d2));
    chk({p, ".count"},       32'(cnt[k]), 32'(e.cnt));
  endtask

  // Model advances on the same edge as the DUTs; inputs only move 1 time unit after it.
  always @(posedge clk) begin
    if (rst) started = 1'b1;
    q0 = nxt(q0, 1'b0);
    q1 = nxt(q1, 1'b1);
  end

  always @(negedge clk) begin
    if (started) begin
      cmp_inst(0, expect_outs(q0, 1'b0));
      cmp_inst(1, expect_outs(q1, 1'b1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] a, input logic [15:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = rdy[0];
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance of addr %0d", a);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      done = (cnt[0] == 3'd0) && (cnt[1] == 3'd0);
      if (!done) step();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got count=%0d expected 0", cnt[0]);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    started  = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_addr  = 3'd3;
    in_data  = 16'h1234;
    wb_stall = 1'b0;
    look1    = 3'd3;
    look2    = 3'd0;

    step();
    @(negedge clk);
    chk("reset.write_en", 32'(we[0]),  32'd0);
    chk("reset.count",    32'(cnt[0]), 32'd0);
    chk("reset.in_ready", 32'(rdy[0]), 32'd1);
    chk("reset.look_hit", 32'(h1[0]),  32'd0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;

    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) send(3'(i), 16'(7 - i));
    @(negedge clk);
    chk("fill.count",    32'(cnt[0]), 32'd4);
    chk("fill.in_ready", 32'(rdy[0]), 32'd0);
    step();
    wb_stall = 1'b0;
    @(negedge clk);
    chk("drain.first_en",   32'(we[0]), 32'd1);
    chk("drain.first_addr", 32'(wa[0]), 32'd0);
    chk("drain.first_data", 32'(wd[0]), 32'd7);
    for (int i = 4; i < 8; i++) send(3'(i), 16'(7 - i));
    wait_empty();

    wb_stall = 1'b1;
    send(3'd2, 16'h1111);
    send(3'd2, 16'h2222);
    look1 = 3'd2;
    look2 = 3'd5;
    @(negedge clk);
    chk("fwd.hit1",  32'(h1[0]), 32'd1);
    chk("fwd.data1", 32'(d1[0]), 32'h2222);
    chk("fwd.hit2",  32'(h2[0]), 32'd0);
    chk("fwd.data2", 32'(d2[0]), 32'd0);
    step();
    wb_stall = 1'b0;
    wait_empty();

    for (int c = 0; c < 1500; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_addr  = 3'($urandom);
      in_data  = 16'($urandom);
      wb_stall = ($urandom_range(0, 9) < 3);
      look1    = 3'($urandom);
      look2    = 3'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    wb_stall = 1'b0;
    wait_empty();

    wb_stall = 1'b1;
    send(3'd1, 16'hA001);
    send(3'd2, 16'hA002);
    send(3'd3, 16'hA003);
    @(negedge clk);
    chk("midrst.count_before", 32'(cnt[0]), 32'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.count_after", 32'(cnt[0]), 32'd0);
    chk("midrst.write_en",    32'(we[0]),  32'd0);
    step();
    wb_stall = 1'b0;
    send(3'd5, 16'h0055);
`ifndef WB_BYPASS_EN
    @(negedge clk);
    chk("resume.write_en",   32'(we[0]), 32'd1);
    chk("resume.write_addr", 32'(wa[0]), 32'd5);
    chk("resume.write_data", 32'(wd[0]), 32'h0055);
`endif
    wait_empty();

    send(3'd0, 16'hBEEF);
    @(negedge clk);
    chk("zreg.write_en", 32'(we[1]),  32'd0);
    chk("zreg.count",    32'(cnt[1]), 32'd0);
    wait_empty();
`ifdef WB_BYPASS_EN
    in_valid = 1'b1;
    in_addr  = 3'd4;
    in_data  = 16'h00AA;
    @(negedge clk);
    chk("bypass.write_en",   32'(we[1]), 32'd1);
    chk("bypass.write_addr", 32'(wa[1]), 32'd4);
    chk("bypass.write_data", 32'(wd[1]), 32'h00AA);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bypass.count", 32'(cnt[1]), 32'd0);
`endif
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
